// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared encodings for the memory port arbiter.
// State encoding, port indices and bus width.
package mem_arb_pkg;

  localparam int DW = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic PORT_IF   = 1'b0;
  localparam logic PORT_DATA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side bundle of the port arbiter.
// slave: arbiter view; master: requesters + memory view.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [DW-1:0] addr0;
  logic [DW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          done0;
  logic          done1;
  logic [DW-1:0] rdata;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          sel;

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    input  mem_ack, mem_rdata,
    output done0, done1, rdata, sel,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    output mem_ack, mem_rdata,
    input  done0, done1, rdata, sel,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_mux.sv
// twox1_32bit: 32-bit 2:1 mux steering a port onto the bus.
// Ports: sel, d0 (sel=0), d1 (sel=1), y.
module twox1_32bit (
  input  logic        sel,
  input  logic [31:0] d0,
  input  logic [31:0] d1,
  output logic [31:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter/sequencer for the single memory port.
// Ports: clk, rst_n, bus (slave). Macro MEM_ARB_RR_EN: RR ties.
import mem_arb_pkg::*;

module mem_port_arbiter (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  state_t st;
  logic   sel_q;
  logic   we_q;
  logic   req_q;
  logic   win;

`ifdef MEM_ARB_RR_EN
  logic last;

  // Tie goes to the port that was not served last.
  assign win = (bus.req0 & bus.req1) ? ~last
                                     : bus.req1;
`else
  // Data port always wins ties.
  assign win = bus.req1 ? PORT_DATA : PORT_IF;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= ST_IDLE;
      sel_q <= PORT_IF;
      we_q  <= 1'b0;
      req_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last  <= PORT_DATA;
`endif
    end else begin
      unique case (st)
        ST_IDLE: begin
          if (bus.req0 | bus.req1) begin
            st    <= ST_BUSY;
            sel_q <= win;
            we_q  <= win ? bus.we1 : bus.we0;
            req_q <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (bus.mem_ack) begin
            st    <= ST_IDLE;
            we_q  <= 1'b0;
            req_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last  <= sel_q;
`endif
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  twox1_32bit u_addr_mux (
    .sel (sel_q),
    .d0  (bus.addr0),
    .d1  (bus.addr1),
    .y   (bus.mem_addr)
  );

  twox1_32bit u_wdata_mux (
    .sel (sel_q),
    .d0  (bus.wdata0),
    .d1  (bus.wdata1),
    .y   (bus.mem_wdata)
  );

  logic fin;
  assign fin = (st == ST_BUSY) & bus.mem_ack;

  assign bus.done0   = fin & (sel_q == PORT_IF);
  assign bus.done1   = fin & (sel_q == PORT_DATA);
  assign bus.rdata   = bus.mem_rdata;
  assign bus.sel     = sel_q;
  assign bus.mem_req = req_q;
  assign bus.mem_we  = we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Expected values are hand-derived per build (MEM_ARB_RR_EN or not).
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [3:0] ord;
  logic       tie_after_rst;

  initial begin
    n_cmp = 0;
    n_bad = 0;
`ifdef MEM_ARB_RR_EN
    ord           = 4'b1010;
    tie_after_rst = 1'b0;
`else
    ord           = 4'b1111;
    tie_after_rst = 1'b1;
`endif
    rst_n          = 1'b0;
    bus.req0       = 1'b0;
    bus.req1       = 1'b0;
    bus.we0        = 1'b0;
    bus.we1        = 1'b0;
    bus.addr0      = 32'h0000_0040;
    bus.addr1      = 32'h1000_0008;
    bus.wdata0     = 32'h1111_2222;
    bus.wdata1     = 32'hDEAD_BEEF;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'h0;
    #1;
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_sel", 32'(bus.sel), 0);
    chk("rst_done0", 32'(bus.done0), 0);
    chk("rst_done1", 32'(bus.done1), 0);
    chk("rst_addr", bus.mem_addr, 32'h40);
    chk("rst_wdata", bus.mem_wdata, 32'h1111_2222);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // fetch read
    bus.req0 = 1'b1;
    #1;
    chk("t1_req_pre", 32'(bus.mem_req), 0);
    tick();
    chk("t1_mem_req", 32'(bus.mem_req), 1);
    chk("t1_addr", bus.mem_addr, 32'h40);
    chk("t1_sel", 32'(bus.sel), 0);
    chk("t1_we", 32'(bus.mem_we), 0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h2402_0005;
    #1;
    chk("t1_done0", 32'(bus.done0), 1);
    chk("t1_done1", 32'(bus.done1), 0);
    chk("t1_rdata", bus.rdata, 32'h2402_0005);
    tick();
    bus.mem_ack = 1'b0;
    bus.req0    = 1'b0;
    #1;
    chk("t1_idle", 32'(bus.mem_req), 0);
    chk("t1_done0_off", 32'(bus.done0), 0);

    // data store, 3 wait cycles
    bus.req1 = 1'b1;
    bus.we1  = 1'b1;
    tick();
    chk("t2_we", 32'(bus.mem_we), 1);
    chk("t2_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("t2_addr", bus.mem_addr, 32'h1000_0008);
    chk("t2_sel", 32'(bus.sel), 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_wait_done1", 32'(bus.done1), 0);
      chk("t2_wait_req", 32'(bus.mem_req), 1);
      tick();
    end
    bus.mem_ack = 1'b1;
    #1;
    chk("t2_done1", 32'(bus.done1), 1);
    chk("t2_done0", 32'(bus.done0), 0);
    tick();
    bus.mem_ack = 1'b0;
    bus.req1    = 1'b0;
    bus.we1     = 1'b0;
    #1;
    chk("t2_done1_off", 32'(bus.done1), 0);
    chk("t2_idle", 32'(bus.mem_req), 0);
    chk("t2_we_off", 32'(bus.mem_we), 0);

    // both held, immediate acks
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_grant", 32'(bus.sel), 32'(ord[i]));
      bus.mem_ack = 1'b1;
      #1;
      chk("t3_done0", 32'(bus.done0), 32'(!ord[i]));
      chk("t3_done1", 32'(bus.done1), 32'(ord[i]));
      tick();
      bus.mem_ack = 1'b0;
      if (i == 3) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
    end

    // fetch alone, then tie goes to data, reset mid-BUSY
    bus.req0 = 1'b1;
    tick();
    bus.req0    = 1'b0;
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    bus.req0    = 1'b1;
    bus.req1    = 1'b1;
    tick();
    chk("t4_grant", 32'(bus.sel), 1);
    bus.mem_ack = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_req", 32'(bus.mem_req), 0);
    chk("t4_rst_sel", 32'(bus.sel), 0);
    chk("t4_rst_done0", 32'(bus.done0), 0);
    chk("t4_rst_done1", 32'(bus.done1), 0);
    bus.mem_ack = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t4_tie", 32'(bus.sel), 32'(tie_after_rst));
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    bus.req0    = 1'b0;
    bus.req1    = 1'b0;
    tick();

    // ack while idle
    bus.mem_ack = 1'b1;
    #1;
    chk("t5_done0", 32'(bus.done0), 0);
    chk("t5_done1", 32'(bus.done1), 0);
    tick();
    bus.mem_ack = 1'b0;
    #1;
    chk("t5_idle", 32'(bus.mem_req), 0);

    // req0 dropped mid-BUSY
    bus.req0 = 1'b1;
    tick();
    bus.req0 = 1'b0;
    tick();
    chk("t6_hold", 32'(bus.mem_req), 1);
    chk("t6_sel", 32'(bus.sel), 0);
    bus.mem_ack = 1'b1;
    #1;
    chk("t6_done0", 32'(bus.done0), 1);
    tick();
    bus.mem_ack = 1'b0;
    #1;
    chk("t6_idle", 32'(bus.mem_req), 0);
    chk("t6_done0_off", 32'(bus.done0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
